// File: rtl/wbuinarb.sv
// Two-source byte arbiter in front of the debug-bus input chain; the grant stays
// locked to one source until it and the chain have been idle for TIMEOUT cycles.
// Define WBUINARB_SKID_EN for a registered output stage with a 1-entry skid buffer.
module wbuinarb #(
   parameter int TIMEOUT = 1024,
   localparam int LGTIMEOUT = $clog2(TIMEOUT)
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_a_stb,
   output logic       o_a_busy,
   input  logic [7:0] i_a_byte,
   input  logic       i_b_stb,
   output logic       o_b_busy,
   input  logic [7:0] i_b_byte,
   output logic       o_stb,
   input  logic       i_busy,
   output logic [7:0] o_byte,
   input  logic       i_active,
   output logic       o_sel,
   output logic       o_owned
);

   typedef enum logic {IDLE, OWN} state_t;

   state_t               state, state_next;
   logic                 sel;
   logic                 last_winner;
   logic [LGTIMEOUT-1:0] count;
   logic                 owner_stb;
   logic [7:0]           owner_byte;
   logic                 owner_busy;
   logic                 pipe_busy;
   logic                 win;
   logic                 hold;
   logic                 release_now;

   always_comb begin
      owner_stb   = sel ? i_b_stb : i_a_stb;
      owner_byte  = sel ? i_b_byte : i_a_byte;
      win         = (i_a_stb && i_b_stb) ? !last_winner : i_b_stb;
      hold        = owner_stb || i_active || pipe_busy;
      release_now = (state == OWN) && !hold && (count == LGTIMEOUT'(TIMEOUT - 1));
      state_next  = state;
      case (state)
         IDLE:    if (i_a_stb || i_b_stb) state_next = OWN;
         OWN:     if (release_now) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Only the owner ever sees a non-stalled handshake.
   always_comb begin
      o_a_busy = 1'b1;
      o_b_busy = 1'b1;
      if (state == OWN) begin
         if (sel)
            o_b_busy = owner_busy;
         else
            o_a_busy = owner_busy;
      end
   end

   assign o_owned = (state == OWN);
   assign o_sel   = sel;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state       <= IDLE;
         sel         <= 1'b0;
         last_winner <= 1'b1;
         count       <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               count <= '0;
               if (i_a_stb || i_b_stb)
                  sel <= win;
            end
            OWN: begin
               if (release_now) begin
                  last_winner <= sel;
                  count       <= '0;
               end else if (hold)
                  count <= '0;
               else
                  count <= count + 1'b1;
            end
            default: count <= '0;
         endcase
      end
   end

`ifdef WBUINARB_SKID_EN
   logic       out_valid;
   logic [7:0] out_byte;
   logic       skid_valid;
   logic [7:0] skid_byte;
   logic       in_fire;

   assign in_fire    = (state == OWN) && owner_stb && !skid_valid;
   assign owner_busy = skid_valid;
   assign pipe_busy  = out_valid || skid_valid;
   assign o_stb      = out_valid;
   assign o_byte     = out_byte;

   // A byte accepted while the output register is stalled parks in the skid slot.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         out_valid  <= 1'b0;
         out_byte   <= 8'h00;
         skid_valid <= 1'b0;
         skid_byte  <= 8'h00;
      end else if (!out_valid || !i_busy) begin
         if (skid_valid) begin
            out_valid  <= 1'b1;
            out_byte   <= skid_byte;
            skid_valid <= 1'b0;
         end else begin
            out_valid <= in_fire;
            if (in_fire)
               out_byte <= owner_byte;
         end
      end else if (in_fire) begin
         skid_valid <= 1'b1;
         skid_byte  <= owner_byte;
      end
   end
`else
   assign owner_busy = i_busy;
   assign pipe_busy  = 1'b0;
   assign o_stb      = (state == OWN) && owner_stb;
   assign o_byte     = (state == OWN) ? owner_byte : 8'h00;
`endif

endmodule

// File: tb/tb_wbuinarb.sv
// Scoreboard bench for wbuinarb: directed arbitration/timeout scenarios followed
// by randomized traffic, with a transaction-level grant model.
module tb_wbuinarb;

   localparam int TIMEOUT = 8;
`ifdef WBUINARB_SKID_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   logic       i_clk = 1'b0;
   logic       i_reset;
   logic       i_a_stb, i_b_stb, i_busy, i_active;
   logic [7:0] i_a_byte, i_b_byte;
   logic       o_a_busy, o_b_busy, o_stb, o_sel, o_owned;
   logic [7:0] o_byte;

   int         vectors = 0;
   int         miscompares = 0;
   logic [8:0] exp_q[$];
   bit         model_last = 1'b1;
   bit         model_owner = 1'b0;
   bit         exp_win = 1'b0;
   bit         grant_pend = 1'b0;
   bit         was_owned = 1'b0;
   bit         a_acc, b_acc;

   wbuinarb #(.TIMEOUT(TIMEOUT)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_a_stb(i_a_stb), .o_a_busy(o_a_busy), .i_a_byte(i_a_byte),
      .i_b_stb(i_b_stb), .o_b_busy(o_b_busy), .i_b_byte(i_b_byte),
      .o_stb(o_stb), .i_busy(i_busy), .o_byte(o_byte),
      .i_active(i_active), .o_sel(o_sel), .o_owned(o_owned)
   );

   always #5 i_clk = ~i_clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      vectors++;
      if (actual != expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Present one byte from a source and hold it until the handshake completes.
   task automatic applyStimulus(input bit src, input logic [7:0] val);
      int  n = 0;
      bit  done = 0;
      bit  busy;
      if (src) begin i_b_stb = 1'b1; i_b_byte = val; end
      else     begin i_a_stb = 1'b1; i_a_byte = val; end
      while (!done) begin
         #1;
         busy = src ? o_b_busy : o_a_busy;
         tick();
         n++;
         if (!busy) done = 1;
         else if (n > 50 * TIMEOUT) begin
            vectors++; miscompares++;
            $display("[TB] FAIL accept_timeout: src %0d byte 0x%0h never accepted", src, val);
            done = 1;
         end
      end
      if (src) i_b_stb = 1'b0;
      else     i_a_stb = 1'b0;
   endtask

   task automatic waitRelease(input string name, input int expected);
      int n = 0;
      #1;
      while (o_owned && n < 20 * TIMEOUT) begin
         tick();
         #1;
         n++;
      end
      checkOutput(name, n, expected);
   endtask

   task automatic doReset();
      i_reset = 1'b1;
      exp_q.delete();
      repeat (2) tick();
      i_reset = 1'b0;
   endtask

   // Expected stream: every byte a source hands over, tagged with its source.
   always @(negedge i_clk) begin
      if (!i_reset) begin
         if (i_a_stb && !o_a_busy) exp_q.push_back({1'b0, i_a_byte});
         if (i_b_stb && !o_b_busy) exp_q.push_back({1'b1, i_b_byte});
      end
   end

   always @(negedge i_clk) begin
      logic [8:0] e;
      #1;
      if (!i_reset && o_stb && !i_busy) begin
         if (exp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("[TB] FAIL unexpected_byte: got 0x%0h sel %0d, expected none", o_byte, o_sel);
         end else begin
            e = exp_q.pop_front();
            checkOutput("out_byte", o_byte, e[7:0]);
            checkOutput("out_sel", o_sel, e[8]);
         end
      end
   end

   // Grant model: lone requester wins, a tie goes to whoever did not win last.
   always @(negedge i_clk) begin
      if (i_reset) begin
         model_last = 1'b1;
         grant_pend = 1'b0;
         was_owned  = 1'b0;
      end else begin
         if (grant_pend) begin
            checkOutput("grant_owned", o_owned, 1);
            checkOutput("grant_sel", o_sel, exp_win);
            model_owner = exp_win;
            grant_pend  = 1'b0;
         end else if (was_owned && !o_owned) begin
            model_last = model_owner;
         end
         if (!o_owned && (i_a_stb || i_b_stb)) begin
            exp_win    = (i_a_stb && i_b_stb) ? !model_last : i_b_stb;
            grant_pend = 1'b1;
         end
         if (o_owned && !grant_pend)
            checkOutput("nonowner_busy", model_owner ? o_a_busy : o_b_busy, 1);
         was_owned = o_owned;
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int acc;
      int rate;
      int guard;
      bit took;
      i_reset = 1'b1;
      i_a_stb = 0; i_b_stb = 0; i_busy = 0; i_active = 0;
      i_a_byte = 0; i_b_byte = 0;
      #1;
      checkOutput("reset_owned", o_owned, 0);
      checkOutput("reset_sel", o_sel, 0);
      checkOutput("reset_stb", o_stb, 0);
      checkOutput("reset_byte", o_byte, 0);
      checkOutput("reset_a_busy", o_a_busy, 1);
      checkOutput("reset_b_busy", o_b_busy, 1);
      repeat (2) tick();
      i_reset = 1'b0;

      $display("[TB] single source A stream");
      i_a_stb = 1'b1; i_a_byte = 8'h41;
      #1;
      checkOutput("idle_owned", o_owned, 0);
      checkOutput("idle_a_busy", o_a_busy, 1);
      tick();
      #1;
      checkOutput("t1_owned", o_owned, 1);
      checkOutput("t1_sel", o_sel, 0);
      checkOutput("t1_a_busy", o_a_busy, 0);
      checkOutput("t1_b_busy", o_b_busy, 1);
      tick();
      i_a_byte = 8'h42;
      tick();
      i_a_stb = 1'b0;
      waitRelease("t1_release", TIMEOUT + LAT);

      $display("[TB] tie, then timeout hands over to B");
      doReset();
      i_a_stb = 1'b1; i_a_byte = 8'h10;
      i_b_stb = 1'b1; i_b_byte = 8'h20;
      tick();
      #1;
      checkOutput("t2_tie_sel", o_sel, 0);
      tick();
      i_a_stb = 1'b0;
      waitRelease("t2_release_a", TIMEOUT + LAT);
      checkOutput("t2_sel_kept", o_sel, 0);
      tick();
      #1;
      checkOutput("t2_b_sel", o_sel, 1);
      checkOutput("t2_b_busy", o_b_busy, 0);
      tick();
      i_b_stb = 1'b0;
      waitRelease("t2_release_b", TIMEOUT + LAT);

      $display("[TB] owner byte on the release cycle");
      applyStimulus(0, 8'h31);
      repeat (TIMEOUT + LAT - 1) tick();
      applyStimulus(0, 8'h32);
      #1;
      checkOutput("t3_still_owned", o_owned, 1);
      checkOutput("t3_sel", o_sel, 0);
      waitRelease("t3_release", TIMEOUT + LAT);

      $display("[TB] i_active holds the grant");
      applyStimulus(0, 8'h51);
      i_active = 1'b1;
      repeat (3 * TIMEOUT) tick();
      #1;
      checkOutput("t4_held", o_owned, 1);
      i_active = 1'b0;
      waitRelease("t4_release", TIMEOUT);

      $display("[TB] downstream stall");
      applyStimulus(0, 8'h60);
      tick();
      i_busy = 1'b1;
      i_a_stb = 1'b1; i_a_byte = 8'h7E;
      acc = 0;
      repeat (20) begin
         #1;
         took = i_a_stb && !o_a_busy;
         tick();
         if (took) begin acc++; i_a_stb = 1'b0; end
      end
      checkOutput("t5_accepts", acc, LAT);
      #1;
      checkOutput("t5_stb", o_stb, 1);
      checkOutput("t5_byte", o_byte, 8'h7E);
      checkOutput("t5_owned", o_owned, 1);
      i_busy = 1'b0;
      tick();
      i_a_stb = 1'b0;
      waitRelease("t5_release", TIMEOUT);

      $display("[TB] reset while B owns the grant");
      applyStimulus(1, 8'h80);
      applyStimulus(1, 8'h81);
      i_b_stb = 1'b1; i_b_byte = 8'h82;
      #2;
      i_reset = 1'b1;
      exp_q.delete();
      #1;
      checkOutput("t6_owned", o_owned, 0);
      checkOutput("t6_stb", o_stb, 0);
      checkOutput("t6_a_busy", o_a_busy, 1);
      checkOutput("t6_b_busy", o_b_busy, 1);
      repeat (2) tick();
      i_reset = 1'b0;
      i_a_stb = 1'b1; i_a_byte = 8'h90;
      i_b_stb = 1'b1; i_b_byte = 8'hA0;
      tick();
      #1;
      checkOutput("t6_tie_sel", o_sel, 0);
      checkOutput("t6_tie_owned", o_owned, 1);
      tick();
      i_a_stb = 1'b0;
      a_acc = 1'b0; b_acc = 1'b0;

      $display("[TB] randomized traffic");
      rate = 2;
      for (int c = 0; c < 3000; c++) begin
         if (c % 250 == 0) rate = ($urandom % 2) ? 2 : 12;
         if (!i_a_stb || a_acc) begin
            i_a_stb = ($urandom % rate) == 0;
            i_a_byte = 8'($urandom);
         end
         if (!i_b_stb || b_acc) begin
            i_b_stb = ($urandom % rate) == 0;
            i_b_byte = 8'($urandom);
         end
         i_busy = ($urandom % 4) == 0;
         i_active = ($urandom % 20) == 0;
         #1;
         a_acc = i_a_stb && !o_a_busy;
         b_acc = i_b_stb && !o_b_busy;
         tick();
      end

      i_busy = 1'b0;
      i_active = 1'b0;
      guard = 0;
      while ((i_a_stb || i_b_stb) && guard < 20 * TIMEOUT) begin
         #1;
         a_acc = i_a_stb && !o_a_busy;
         b_acc = i_b_stb && !o_b_busy;
         tick();
         if (a_acc) i_a_stb = 1'b0;
         if (b_acc) i_b_stb = 1'b0;
         guard++;
      end
      checkOutput("drain_sources", int'(i_a_stb || i_b_stb), 0);
      repeat (3 * TIMEOUT) tick();
      checkOutput("queue_drained", exp_q.size(), 0);
      checkOutput("final_released", o_owned, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
